nano_mem: RTL

Parametrised single-port memory for the NanoCPU, replacing the 256×16 zero-wait array with a configurable-latency slave. Storage depth, data width and wait-state count are parameters. A request/ready handshake lets the CPU stall on slow memory. The block sits between the NanoCPU bus (address, dataW, dataR, ce, we) and the rest of the system. It also flags out-of-range accesses.

---
 rtl/nano_mem.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/nano_mem.sv
// ============================================================================
//  Module   : nano_mem
//  Purpose  : Parametrised single-port word memory for the NanoCPU bus with a
//             configurable number of wait states and a ce/ready handshake.
//             Accesses whose latched address falls at or above DEPTH are
//             flagged with err; such writes are dropped and reads return 0.
//
//  Ports    : ck       in   clock, rising edge
//             rst      in   synchronous reset, active low
//             ce       in   access request, held with address/we/dataW
//                           until ready
//             we       in   1 = write, 0 = read
//             address  in   [ADDR_W-1:0] word address
//             dataW    in   [DATA_W-1:0] write data
//             dataR    out  [DATA_W-1:0] registered read data, held until
//                           the next read completes
//             ready    out  one-cycle completion pulse
//             err      out  high with ready for an out-of-range access
//
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nano_mem #(
    parameter int    DATA_W      = 16,
    parameter int    ADDR_W      = 8,
    parameter int    DEPTH       = 256,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              ce,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataW,
    output logic [DATA_W-1:0] dataR,
    output logic              ready,
    output logic              err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_STATES);
    localparam bit         C_NO_WAIT   = (WAIT_STATES == 0);

    // Index width of the implemented array; never wider than ADDR_W since
    // DEPTH is bounded by 2**ADDR_W.
    localparam int C_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ------------------------------------------------------------------
    // Storage and registered state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;

    logic [DATA_W-1:0] r_data_r;
    logic              r_ready;
    logic              r_err;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [1:0]         w_state_next;
    logic               w_accept;
    logic               w_commit;
    logic [ADDR_W-1:0]  w_acc_addr;
    logic               w_acc_we;
    logic [DATA_W-1:0]  w_acc_wdata;
    logic               w_oob;
    logic [C_IDX_W-1:0] w_idx;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge ck) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (ce) begin
                    w_state_next = C_NO_WAIT ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                // The counter hits zero on the edge that leaves WAIT.
                if (r_cnt == 4'd1) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // ce is deliberately ignored so a held request is not
                // serviced twice.
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_accept = (r_state == S_IDLE) && ce;

        // With no wait states the access completes on the accepting edge,
        // so the live bus values stand in for the latched copies.
        w_commit = (w_accept && C_NO_WAIT) ||
                   ((r_state == S_WAIT) && (r_cnt == 4'd1));

        if (r_state == S_IDLE) begin
            w_acc_addr  = address;
            w_acc_we    = we;
            w_acc_wdata = dataW;
        end else begin
            w_acc_addr  = r_addr;
            w_acc_we    = r_we;
            w_acc_wdata = r_wdata;
        end

        // Unsigned compare in 32 bits so DEPTH = 2**ADDR_W never flags.
        w_oob = (32'(w_acc_addr) >= 32'(DEPTH));
        w_idx = w_acc_addr[C_IDX_W-1:0];
    end

    // ------------------------------------------------------------------
    // Request latch and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge ck) begin
        if (!rst) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= C_WAIT_LOAD;
                r_addr  <= address;
                r_we    <= we;
                r_wdata <= dataW;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory write port; reset blocks a commit on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge ck) begin
        if (rst && w_commit && w_acc_we && !w_oob) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Completion outputs: ready/err pulse and read data register
    // ------------------------------------------------------------------
    always_ff @(posedge ck) begin
        if (!rst) begin
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_data_r <= '0;
        end else begin
            r_ready <= w_commit;
            r_err   <= w_commit && w_oob;
            // Only completed reads move dataR; writes leave it untouched.
            if (w_commit && !w_acc_we) begin
                r_data_r <= w_oob ? '0 : r_mem[w_idx];
            end
        end
    end

    assign dataR = r_data_r;
    assign ready = r_ready;
    assign err   = r_err;

endmodule

`default_nettype wire
